// File: rtl/sspim_pkg.sv
// Shared definitions for the SPI master controller: op types, FSM state codes,
// the latched operation configuration and byte-selection helpers.
package sspim_pkg;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WRRD = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_CS_SETUP  = 3'd1;
    localparam state_t ST_LOAD      = 3'd2;
    localparam state_t ST_SHIFT     = 3'd3;
    localparam state_t ST_BYTE_DONE = 3'd4;
    localparam state_t ST_CS_GAP    = 3'd5;
    localparam state_t ST_CS_HOLD   = 3'd6;
    localparam state_t ST_DONE      = 3'd7;

    typedef struct packed {
        logic [1:0]  op_type;
        logic [1:0]  size;
        logic        cs_byte;
        logic [31:0] datain;
    } cfg_t;

    // The reserved code 11 behaves as write-read, so only 00 skips capture.
    function automatic logic op_reads(input logic [1:0] op);
        return op != OP_WR;
    endfunction

    // Byte idx (0 = first sent) of the write word; reads shift out zeros.
    function automatic logic [7:0] tx_byte(input cfg_t cfg, input logic [1:0] idx);
        logic [1:0] sel;
        sel = cfg.size - idx;
        if (cfg.op_type == OP_RD) begin
            return 8'h00;
        end
        return cfg.datain[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sspim_clkgen.sv
// Serial clock divider: while enabled, toggles sck every half_m1+1 clk cycles
// starting low, with one-cycle pulses in the first cycle after each edge.
module sspim_clkgen #(
    parameter int SCK_DIV_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [SCK_DIV_W-1:0] half_m1,
    output logic                 sck_int,
    output logic                 sck_pe,
    output logic                 sck_ne
);

    logic [SCK_DIV_W-1:0] div_cnt_reg;
    logic                 sck_reg;
    logic                 pe_reg;
    logic                 ne_reg;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt_reg <= '0;
            sck_reg     <= 1'b0;
            pe_reg      <= 1'b0;
            ne_reg      <= 1'b0;
        end else begin
            pe_reg <= 1'b0;
            ne_reg <= 1'b0;
            if (div_cnt_reg == half_m1) begin
                div_cnt_reg <= '0;
                sck_reg     <= ~sck_reg;
                pe_reg      <= ~sck_reg;
                ne_reg      <= sck_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
        end
    end

    assign sck_int = sck_reg;
    assign sck_pe  = pe_reg;
    assign sck_ne  = ne_reg;

endmodule

// File: rtl/sspim_ctl.sv
// SPI master operation sequencer (mode 0): chip-select framing, per-byte load
// and shift control for the interface block, and read-data accumulation.
module sspim_ctl #(
    parameter int SCK_DIV_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_op_req,
    input  logic [1:0]           cfg_op_type,
    input  logic [1:0]           cfg_transfer_size,
    input  logic [SCK_DIV_W-1:0] cfg_sck_period,
    input  logic                 cfg_cs_byte,
    input  logic [31:0]          cfg_datain,
    output logic [31:0]          cfg_dataout,
    output logic                 busy,
    output logic                 op_done,
    output logic                 sck_int,
    output logic                 sck_pe,
    output logic                 cs_int_n,
    output logic                 load_byte,
    output logic                 shift_out,
    output logic                 shift_in,
    output logic [7:0]           byte_out,
    input  logic [7:0]           byte_in
);

    import sspim_pkg::*;

    state_t               state_reg;
    state_t               state_next;
    cfg_t                 cfg_reg;
    logic [SCK_DIV_W-1:0] half_m1_reg;
    logic [SCK_DIV_W-1:0] hp_cnt_reg;
    logic [1:0]           byte_cnt_reg;
    logic [2:0]           bit_cnt_reg;
    logic                 shift_first_reg;
    logic [31:0]          dataout_reg;
    logic                 hp_done;
    logic                 sck_ne;
    logic                 clk_en;

    assign hp_done = (hp_cnt_reg == half_m1_reg);
    assign clk_en  = (state_reg == ST_SHIFT);

    sspim_clkgen #(
        .SCK_DIV_W (SCK_DIV_W)
    ) u_clkgen (
        .clk     (clk),
        .reset   (reset),
        .en      (clk_en),
        .half_m1 (half_m1_reg),
        .sck_int (sck_int),
        .sck_pe  (sck_pe),
        .sck_ne  (sck_ne)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (cfg_op_req) state_next = ST_CS_SETUP;
            ST_CS_SETUP:  if (hp_done) state_next = ST_LOAD;
            ST_LOAD:      state_next = ST_SHIFT;
            ST_SHIFT:     if (sck_ne && bit_cnt_reg == 3'd7) state_next = ST_BYTE_DONE;
            ST_BYTE_DONE: begin
                if (byte_cnt_reg == cfg_reg.size) begin
                    state_next = ST_CS_HOLD;
                end else if (cfg_reg.cs_byte) begin
                    state_next = ST_CS_GAP;
                end else begin
                    state_next = ST_LOAD;
                end
            end
            ST_CS_GAP:    if (hp_done) state_next = ST_CS_SETUP;
            ST_CS_HOLD:   if (hp_done) state_next = ST_DONE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cfg_reg         <= '0;
            half_m1_reg     <= '0;
            hp_cnt_reg      <= '0;
            byte_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            shift_first_reg <= 1'b0;
            dataout_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            // Half-period timer restarts on every state change.
            hp_cnt_reg      <= (state_next != state_reg) ? '0 : hp_cnt_reg + 1'b1;
            shift_first_reg <= (state_reg == ST_LOAD);
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_op_req) begin
                        cfg_reg.op_type <= cfg_op_type;
                        cfg_reg.size    <= cfg_transfer_size;
                        cfg_reg.cs_byte <= cfg_cs_byte;
                        cfg_reg.datain  <= cfg_datain;
                        half_m1_reg     <= (cfg_sck_period == '0) ? SCK_DIV_W'(1) : cfg_sck_period;
                        dataout_reg     <= '0;
                        byte_cnt_reg    <= '0;
                    end
                end
                ST_LOAD: begin
                    bit_cnt_reg <= '0;
                end
                ST_SHIFT: begin
                    if (sck_ne) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                ST_BYTE_DONE: begin
                    if (op_reads(cfg_reg.op_type)) begin
                        dataout_reg <= {dataout_reg[23:0], byte_in};
                    end
                    if (byte_cnt_reg != cfg_reg.size) begin
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_dataout = dataout_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign op_done     = (state_reg == ST_DONE);
    assign cs_int_n    = (state_reg == ST_IDLE) || (state_reg == ST_CS_GAP) || (state_reg == ST_DONE);
    assign load_byte   = (state_reg == ST_LOAD);
    assign byte_out    = tx_byte(cfg_reg, byte_cnt_reg);
    assign shift_in    = (state_reg == ST_SHIFT) && op_reads(cfg_reg.op_type);
    // MSB is presented right after LOAD, then one bit per falling edge except the last.
    assign shift_out   = (state_reg == ST_SHIFT) &&
                         (shift_first_reg || (sck_ne && bit_cnt_reg != 3'd7));

endmodule

// File: tb/tb_sspim_ctl.sv
// Self-checking bench for sspim_ctl: cycle-level waveform model built from
// per-phase durations, a loopback/slave interface model, and directed scenarios.
module tb_sspim_ctl;

    localparam int W = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_op_req;
    logic [1:0]    cfg_op_type;
    logic [1:0]    cfg_transfer_size;
    logic [W-1:0]  cfg_sck_period;
    logic          cfg_cs_byte;
    logic [31:0]   cfg_datain;
    logic [31:0]   cfg_dataout;
    logic          busy, op_done, sck_int, sck_pe, cs_int_n;
    logic          load_byte, shift_out, shift_in;
    logic [7:0]    byte_out, byte_in;

    always #5 clk = ~clk;

    sspim_ctl #(.SCK_DIV_W(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_op_req        (cfg_op_req),
        .cfg_op_type       (cfg_op_type),
        .cfg_transfer_size (cfg_transfer_size),
        .cfg_sck_period    (cfg_sck_period),
        .cfg_cs_byte       (cfg_cs_byte),
        .cfg_datain        (cfg_datain),
        .cfg_dataout       (cfg_dataout),
        .busy              (busy),
        .op_done           (op_done),
        .sck_int           (sck_int),
        .sck_pe            (sck_pe),
        .cs_int_n          (cs_int_n),
        .load_byte         (load_byte),
        .shift_out         (shift_out),
        .shift_in          (shift_in),
        .byte_out          (byte_out),
        .byte_in           (byte_in)
    );

    // ---------------- interface block / slave model ----------------
    logic [7:0] tx_sr = 8'h00, rx_sr = 8'h00, slv_sr = 8'h00;
    logic       mosi = 1'b0, smiso = 1'b0, loop_mode = 1'b1;
    logic       miso;
    logic [7:0] slave_q[$];

    assign miso    = loop_mode ? mosi : smiso;
    assign byte_in = rx_sr;

    always @(posedge clk) begin
        if (load_byte) begin
            tx_sr <= byte_out;
            if (slave_q.size() > 0) slv_sr <= slave_q.pop_front();
            else                    slv_sr <= 8'h00;
        end
        if (shift_out) begin
            mosi   <= tx_sr[7];
            tx_sr  <= {tx_sr[6:0], 1'b0};
            smiso  <= slv_sr[7];
            slv_sr <= {slv_sr[6:0], 1'b0};
        end
        if (sck_pe && shift_in) rx_sr <= {rx_sr[6:0], miso};
    end

    // ---------------- expected waveform model ----------------
    typedef struct packed {
        logic        cs_n, sck, pe, busy, done, load, sin, chk;
        logic [31:0] dout;
    } exp_t;

    exp_t exp_q[$];
    logic mosi_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic cs_n, sck, pe, bsy, done, load, sin, chk, input logic [31:0] dout);
        exp_t e;
        e.cs_n = cs_n; e.sck = sck; e.pe = pe; e.busy = bsy; e.done = done;
        e.load = load; e.sin = sin; e.chk = chk; e.dout = dout;
        exp_q.push_back(e);
    endtask

    // Builds the cycle-by-cycle outputs following acceptance of one operation.
    task automatic push_op(input logic [1:0] op, input logic [1:0] sz, input int per,
                           input logic csb, input logic [31:0] din, input logic lead,
                           input logic lp, input logic [31:0] sdata);
        int h, n;
        logic rd, wr;
        logic [7:0] txb, rxb;
        logic [31:0] dout;
        h = ((per == 0) ? 1 : per) + 1;
        n = int'(sz) + 1;
        rd = (op != 2'b00);
        wr = (op != 2'b01);
        dout = 32'h0;
        if (lead) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (h) add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int b = 0; b < n; b++) begin
            txb = wr ? din[8*(n-1-b) +: 8] : 8'h00;
            rxb = lp ? txb : sdata[8*(n-1-b) +: 8];
            if (!lp) slave_q.push_back(sdata[8*(n-1-b) +: 8]);
            if (rd) dout = {dout[23:0], rxb};
            for (int i = 7; i >= 0; i--) mosi_q.push_back(txb[i]);
            add(0, 0, 0, 1, 0, 1, 0, 0, 0);
            for (int k = 0; k <= 16*h; k++)
                add(0, logic'((k / h) % 2), logic'((k % (2*h)) == h), 1, 0, 0, rd, 0, 0);
            add(0, 0, 0, 1, 0, 0, 0, 0, 0);
            if (b == n - 1) begin
                repeat (h) add(0, 0, 0, 1, 0, 0, 0, 0, 0);
                add(1, 0, 0, 1, 1, 0, 0, 1, dout);
            end else if (csb) begin
                repeat (h) add(1, 0, 0, 1, 0, 0, 0, 0, 0);
                repeat (h) add(0, 0, 0, 1, 0, 0, 0, 0, 0);
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    exp_t cmp_e;
    logic cmp_b;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            checks++;
            if ({cs_int_n, sck_int, sck_pe, busy, op_done, load_byte, shift_in} !==
                {cmp_e.cs_n, cmp_e.sck, cmp_e.pe, cmp_e.busy, cmp_e.done, cmp_e.load, cmp_e.sin}) begin
                errors++;
                $display("FAIL cycle outputs cs_n/sck/pe/busy/done/load/sin at %0t: got %b%b%b%b%b%b%b want %b%b%b%b%b%b%b",
                         $time, cs_int_n, sck_int, sck_pe, busy, op_done, load_byte, shift_in,
                         cmp_e.cs_n, cmp_e.sck, cmp_e.pe, cmp_e.busy, cmp_e.done, cmp_e.load, cmp_e.sin);
            end
            if (cmp_e.chk) begin
                checks++;
                if (cfg_dataout !== cmp_e.dout) begin
                    errors++;
                    $display("FAIL dataout at %0t: got %h want %h", $time, cfg_dataout, cmp_e.dout);
                end
            end
            if (sck_pe && mosi_q.size() > 0) begin
                cmp_b = mosi_q.pop_front();
                checks++;
                if (mosi !== cmp_b) begin
                    errors++;
                    $display("FAIL mosi bit at %0t: got %b want %b", $time, mosi, cmp_b);
                end
            end
        end
    end

    // ---------------- activity monitor ----------------
    int          cyc = 0, pe_cnt = 0, done_cnt = 0, cs_gap_cyc = 0, last_pe = -1, pe_spacing = 0;
    logic [31:0] mosi_bits = 32'h0;

    always @(negedge clk) begin
        cyc++;
        if (sck_pe) begin
            pe_cnt++;
            if (last_pe >= 0) pe_spacing = cyc - last_pe;
            last_pe = cyc;
            mosi_bits = {mosi_bits[30:0], mosi};
        end
        if (op_done) done_cnt++;
        if (busy && cs_int_n && !op_done) cs_gap_cyc++;
    end

    task automatic clr_mon();
        pe_cnt = 0; done_cnt = 0; cs_gap_cyc = 0; last_pe = -1; pe_spacing = 0; mosi_bits = 32'h0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 20000) begin
            @(negedge clk); #1;
            t++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d expected cycles left", exp_q.size());
            exp_q.delete();
            mosi_q.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic scramble_cfg();
        cfg_op_type       = 2'($urandom_range(3, 0));
        cfg_transfer_size = 2'($urandom_range(3, 0));
        cfg_sck_period    = W'($urandom_range(63, 0));
        cfg_cs_byte       = 1'($urandom_range(1, 0));
        cfg_datain        = $urandom;
    endtask

    // Starts from an IDLE cycle (negedge+1); cfg is scrambled after acceptance.
    task automatic run_op(input logic [1:0] op, input logic [1:0] sz, input int per,
                          input logic csb, input logic [31:0] din, input logic lp,
                          input logic [31:0] sdata);
        cfg_op_type       = op;
        cfg_transfer_size = sz;
        cfg_sck_period    = W'(per);
        cfg_cs_byte       = csb;
        cfg_datain        = din;
        loop_mode         = lp;
        cfg_op_req        = 1'b1;
        push_op(op, sz, per, csb, din, 1'b0, lp, sdata);
        @(posedge clk); #1;
        cfg_op_req = 1'b0;
        scramble_cfg();
        wait_idle();
        $display("op type=%0d size=%0d period=%0d cs_byte=%0d datain=%h loop=%0d dataout=%h",
                 op, sz, per, csb, din, lp, cfg_dataout);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        cfg_op_req = 1'b0;
        cfg_op_type = 2'b00;
        cfg_transfer_size = 2'b00;
        cfg_sck_period = '0;
        cfg_cs_byte = 1'b0;
        cfg_datain = 32'h0;
        repeat (3) @(negedge clk);
        check("reset cs_int_n", 32'(cs_int_n), 32'h1);
        check("reset sck_int",  32'(sck_int), 32'h0);
        check("reset busy/done/pe", {29'h0, busy, op_done, sck_pe}, 32'h0);
        check("reset load/shift", {29'h0, load_byte, shift_out, shift_in}, 32'h0);
        check("reset dataout", cfg_dataout, 32'h0);
        check("reset byte_out", 32'(byte_out), 32'h0);
        #1 reset = 1'b0;
        @(negedge clk); #1;

        // write 1 byte, 4-clk sck
        clr_mon();
        run_op(2'b00, 2'd0, 1, 1'b0, 32'h0000_00A5, 1'b1, 32'h0);
        check("wr sck rises", 32'(pe_cnt), 32'd8);
        check("wr sck period", 32'(pe_spacing), 32'd4);
        check("wr mosi byte", {24'h0, mosi_bits[7:0]}, 32'h0000_00A5);
        check("wr op_done count", 32'(done_cnt), 32'd1);

        // read 4 bytes from slave, cs continuously low
        clr_mon();
        run_op(2'b01, 2'd3, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678);
        check("rd dataout", cfg_dataout, 32'h1234_5678);
        check("rd sck rises", 32'(pe_cnt), 32'd32);
        check("rd cs high while busy", 32'(cs_gap_cyc), 32'd0);

        // write-read with cs gap between bytes
        clr_mon();
        run_op(2'b10, 2'd1, 1, 1'b1, 32'h0000_BEEF, 1'b1, 32'h0);
        check("wrrd dataout", cfg_dataout, 32'h0000_BEEF);
        check("wrrd cs gap cycles", 32'(cs_gap_cyc), 32'd2);
        check("wrrd sck rises", 32'(pe_cnt), 32'd16);

        // period 0 behaves as period 1; reserved op with period 2
        clr_mon();
        run_op(2'b00, 2'd0, 0, 1'b0, 32'h0000_003C, 1'b1, 32'h0);
        check("period0 sck period", 32'(pe_spacing), 32'd4);
        clr_mon();
        run_op(2'b11, 2'd0, 2, 1'b0, 32'h0000_00C3, 1'b1, 32'h0);
        check("period2 sck period", 32'(pe_spacing), 32'd6);
        check("reserved op dataout", cfg_dataout, 32'h0000_00C3);

        // reset at the 4th sck rise
        cfg_op_type = 2'b01; cfg_transfer_size = 2'd3; cfg_sck_period = W'(1);
        cfg_cs_byte = 1'b0; cfg_datain = 32'h0; loop_mode = 1'b1;
        cfg_op_req = 1'b1;
        @(posedge clk); #1;
        cfg_op_req = 1'b0;
        n = 0;
        for (int t = 0; t < 2000 && n < 4; t++) begin
            @(negedge clk); #1;
            if (sck_pe) n++;
        end
        check("rise count before reset", 32'(n), 32'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midop reset cs_int_n", 32'(cs_int_n), 32'h1);
        check("midop reset sck_int", 32'(sck_int), 32'h0);
        check("midop reset busy", 32'(busy), 32'h0);
        check("midop reset shift_in/out", {30'h0, shift_in, shift_out}, 32'h0);
        check("midop reset byte_out", 32'(byte_out), 32'h0);
        @(negedge clk); #1;
        reset = 1'b0;
        slave_q.delete();
        @(negedge clk); #1;
        run_op(2'b10, 2'd2, 1, 1'b0, 32'h00A1_B2C3, 1'b1, 32'h0);
        check("post-reset dataout", cfg_dataout, 32'h00A1_B2C3);

        // request held high across three operations, cfg changed mid-op
        clr_mon();
        loop_mode = 1'b1;
        cfg_op_type = 2'b10; cfg_transfer_size = 2'd1; cfg_sck_period = W'(1);
        cfg_cs_byte = 1'b0; cfg_datain = 32'h0000_1234;
        cfg_op_req = 1'b1;
        push_op(2'b10, 2'd1, 1, 1'b0, 32'h0000_1234, 1'b0, 1'b1, 32'h0);
        push_op(2'b11, 2'd0, 2, 1'b0, 32'h0000_005A, 1'b1, 1'b1, 32'h0);
        push_op(2'b11, 2'd0, 2, 1'b0, 32'h0000_005A, 1'b1, 1'b1, 32'h0);
        @(posedge clk); #1;
        cfg_op_type = 2'b11; cfg_transfer_size = 2'd0; cfg_sck_period = W'(2);
        cfg_datain = 32'h0000_005A;
        for (int t = 0; t < 5000 && done_cnt < 2; t++) begin
            @(negedge clk); #1;
        end
        @(posedge clk);
        @(posedge clk); #1;
        cfg_op_req = 1'b0;
        wait_idle();
        check("held req op_done count", 32'(done_cnt), 32'd3);
        check("held req last dataout", cfg_dataout, 32'h0000_005A);
        $display("chained ops done=%0d dataout=%h", done_cnt, cfg_dataout);

        // randomized operations
        for (int i = 0; i < 16; i++) begin
            run_op(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), $urandom_range(3, 0),
                   1'($urandom_range(1, 0)), $urandom, 1'($urandom_range(1, 0)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
